// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and helpers for the branch direction predictor
package bp_pkg;

  localparam int HASH_GSHARE    = 0;
  localparam int HASH_BIMODAL   = 1;
  localparam int MAX_CTR_BITS   = 4;
  localparam int MAX_INDEX_BITS = 12;

  // Saturating up/down step for a counter of 'width' bits held in a max-width container.
  function automatic logic [MAX_CTR_BITS-1:0] sat_update(
    input logic [MAX_CTR_BITS-1:0] ctr,
    input logic                    taken,
    input int                      width
  );
    logic [MAX_CTR_BITS-1:0] ctr_max;
    logic [MAX_CTR_BITS-1:0] result;
    ctr_max = MAX_CTR_BITS'((1 << width) - 1);
    if (taken) begin
      result = (ctr >= ctr_max) ? ctr_max : ctr + MAX_CTR_BITS'(1);
    end else begin
      result = (ctr == '0) ? '0 : ctr - MAX_CTR_BITS'(1);
    end
    return result;
  endfunction

  function automatic logic [MAX_INDEX_BITS-1:0] gshare_hash(
    input logic [MAX_INDEX_BITS-1:0] pc_idx,
    input logic [MAX_INDEX_BITS-1:0] ghr
  );
    return pc_idx ^ ghr;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// rtl/gshare_predictor_if.sv - lookup and resolve bundle between the pipeline and the predictor
interface gshare_predictor_if #(
  parameter int PC_BITS    = 32,
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 8,
  parameter int CTR_BITS   = 2
);

  logic [PC_BITS-1:0]    lookup_pc;
  logic                  lookup_spec;
  logic                  pred_taken;
  logic [CTR_BITS-1:0]   pred_ctr;
  logic [INDEX_BITS-1:0] pred_index;
  logic [GHR_BITS-1:0]   pred_ghr;
  logic                  resolve_valid;
  logic [INDEX_BITS-1:0] resolve_index;
  logic [GHR_BITS-1:0]   resolve_ghr;
  logic                  resolve_pred_taken;
  logic                  resolve_taken;
  logic                  mispredict;

  modport master (
    output lookup_pc, lookup_spec,
    output resolve_valid, resolve_index, resolve_ghr, resolve_pred_taken, resolve_taken,
    input  pred_taken, pred_ctr, pred_index, pred_ghr, mispredict
  );

  modport slave (
    input  lookup_pc, lookup_spec,
    input  resolve_valid, resolve_index, resolve_ghr, resolve_pred_taken, resolve_taken,
    output pred_taken, pred_ctr, pred_index, pred_ghr, mispredict
  );

endinterface

// File: rtl/bp_counter_table.sv
// rtl/bp_counter_table.sv - flop array of saturating counters, async read, sync read-modify-write update
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int CTR_BITS   = 2,
  parameter int CTR_INIT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [CTR_BITS-1:0]     ctr_q [ENTRIES];
  logic [MAX_CTR_BITS-1:0] upd_full;
  logic [CTR_BITS-1:0]     upd_ctr;
  logic                    unused_upd_bits;

  // The read port sees only flop contents, so a same-index update is invisible until the next cycle.
  assign rd_ctr          = ctr_q[rd_index];
  assign upd_full        = sat_update(MAX_CTR_BITS'(ctr_q[upd_index]), upd_taken, CTR_BITS);
  assign upd_ctr         = upd_full[CTR_BITS-1:0];
  assign unused_upd_bits = ^upd_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_BITS'(CTR_INIT);
      end
    end else if (upd_valid) begin
      ctr_q[upd_index] <= upd_ctr;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare/bimodal direction predictor with speculative and committed history
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PC_BITS    = 32,
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 8,
  parameter int CTR_BITS   = 2,
  parameter int CTR_INIT   = 1,
  parameter int HASH_MODE  = 0,
  parameter int STAT_BITS  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  gshare_predictor_if.slave     bp,
  input  logic                  clear_stats,
  output logic [STAT_BITS-1:0]  predictions_made,
  output logic [STAT_BITS-1:0]  correct_predictions,
  output logic [GHR_BITS-1:0]   committed_ghr
);

  logic [GHR_BITS-1:0]       spec_ghr;
  logic [INDEX_BITS-1:0]     pc_idx;
  logic [INDEX_BITS-1:0]     lookup_index;
  logic [MAX_INDEX_BITS-1:0] hash_full;
  logic [CTR_BITS-1:0]       pred_ctr;
  logic                      pred_taken;
  logic                      correct;
  logic [GHR_BITS:0]         spec_cat;
  logic [GHR_BITS:0]         restore_cat;
  logic [GHR_BITS:0]         commit_cat;
  logic                      unused_bits;

  assign pc_idx       = bp.lookup_pc[INDEX_BITS+1:2];
  assign hash_full    = gshare_hash(MAX_INDEX_BITS'(pc_idx), MAX_INDEX_BITS'(spec_ghr));
  assign lookup_index = (HASH_MODE == HASH_BIMODAL) ? pc_idx : hash_full[INDEX_BITS-1:0];

  bp_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS),
    .CTR_INIT   (CTR_INIT)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (lookup_index),
    .rd_ctr    (pred_ctr),
    .upd_valid (bp.resolve_valid),
    .upd_index (bp.resolve_index),
    .upd_taken (bp.resolve_taken)
  );

  assign pred_taken    = pred_ctr[CTR_BITS-1];
  assign bp.pred_taken = pred_taken;
  assign bp.pred_ctr   = pred_ctr;
  assign bp.pred_index = lookup_index;
  assign bp.pred_ghr   = spec_ghr;
  assign correct       = (bp.resolve_taken == bp.resolve_pred_taken);
  assign bp.mispredict = bp.resolve_valid && !correct;

  // Shift-in via a one-bit-wider concat keeps GHR_BITS = 1 on the same path; the dropped MSB is discarded.
  assign spec_cat    = {spec_ghr, pred_taken};
  assign restore_cat = {bp.resolve_ghr, bp.resolve_taken};
  assign commit_cat  = {committed_ghr, bp.resolve_taken};
  assign unused_bits = ^{bp.lookup_pc, hash_full, spec_cat, restore_cat, commit_cat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_ghr            <= '0;
      committed_ghr       <= '0;
      predictions_made    <= '0;
      correct_predictions <= '0;
    end else begin
      if (bp.mispredict) begin
        spec_ghr <= restore_cat[GHR_BITS-1:0];
      end else if (bp.lookup_spec) begin
        spec_ghr <= spec_cat[GHR_BITS-1:0];
      end

      if (bp.resolve_valid) begin
        committed_ghr <= commit_cat[GHR_BITS-1:0];
      end

      // A clear in the same cycle as a resolve drops that resolve from the statistics.
      if (clear_stats) begin
        predictions_made    <= '0;
        correct_predictions <= '0;
      end else if (bp.resolve_valid) begin
        if (predictions_made != '1) begin
          predictions_made <= predictions_made + STAT_BITS'(1);
        end
        if (correct && (correct_predictions != '1)) begin
          correct_predictions <= correct_predictions + STAT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - directed self-checking bench for gshare_predictor
module tb_gshare_predictor;

  logic        clk;
  logic        rst;
  logic        clear_a, clear_b, clear_c;
  logic [12:0] made_a, corr_a;
  logic [12:0] made_b, corr_b;
  logic [2:0]  made_c, corr_c;
  logic [7:0]  cghr_a, cghr_c;
  logic [3:0]  cghr_b;
  int          n_checks;
  int          n_pass;

  gshare_predictor_if #(.PC_BITS(32), .INDEX_BITS(8), .GHR_BITS(8), .CTR_BITS(2)) if_a ();
  gshare_predictor_if #(.PC_BITS(32), .INDEX_BITS(4), .GHR_BITS(4), .CTR_BITS(3)) if_b ();
  gshare_predictor_if #(.PC_BITS(32), .INDEX_BITS(8), .GHR_BITS(8), .CTR_BITS(2)) if_c ();

  gshare_predictor dut_a (
    .clk (clk), .rst (rst), .bp (if_a.slave), .clear_stats (clear_a),
    .predictions_made (made_a), .correct_predictions (corr_a), .committed_ghr (cghr_a)
  );

  gshare_predictor #(
    .INDEX_BITS (4), .GHR_BITS (4), .CTR_BITS (3), .CTR_INIT (3), .HASH_MODE (1)
  ) dut_b (
    .clk (clk), .rst (rst), .bp (if_b.slave), .clear_stats (clear_b),
    .predictions_made (made_b), .correct_predictions (corr_b), .committed_ghr (cghr_b)
  );

  gshare_predictor #(.STAT_BITS (3)) dut_c (
    .clk (clk), .rst (rst), .bp (if_c.slave), .clear_stats (clear_c),
    .predictions_made (made_c), .correct_predictions (corr_c), .committed_ghr (cghr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up_a[4]   = '{2, 3, 3, 3};
  int dn_a[5]   = '{2, 1, 0, 0, 0};
  int ghr_a[3]  = '{8'h01, 8'h03, 8'h07};
  int up_b[5]   = '{4, 5, 6, 7, 7};
  int stat_c[9] = '{1, 2, 3, 4, 5, 6, 7, 7, 7};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    clear_a  = 1'b0;
    clear_b  = 1'b0;
    clear_c  = 1'b0;
    if_a.lookup_pc = '0; if_a.lookup_spec = 1'b0; if_a.resolve_valid = 1'b0;
    if_a.resolve_index = '0; if_a.resolve_ghr = '0;
    if_a.resolve_pred_taken = 1'b0; if_a.resolve_taken = 1'b0;
    if_b.lookup_pc = '0; if_b.lookup_spec = 1'b0; if_b.resolve_valid = 1'b0;
    if_b.resolve_index = '0; if_b.resolve_ghr = '0;
    if_b.resolve_pred_taken = 1'b0; if_b.resolve_taken = 1'b0;
    if_c.lookup_pc = '0; if_c.lookup_spec = 1'b0; if_c.resolve_valid = 1'b0;
    if_c.resolve_index = '0; if_c.resolve_ghr = '0;
    if_c.resolve_pred_taken = 1'b0; if_c.resolve_taken = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Disturb state, then reset asynchronously mid-cycle.
    if_a.lookup_pc = 32'h40;
    if_a.resolve_valid = 1'b1; if_a.resolve_index = 8'h10;
    if_a.resolve_pred_taken = 1'b1; if_a.resolve_taken = 1'b1;
    tick();
    tick();
    if_a.resolve_valid = 1'b0;
    #1;
    check("pre_rst_ctr", 32'(if_a.pred_ctr), 32'd3);
    check("pre_rst_cghr", 32'(cghr_a), 32'h03);
    check("pre_rst_made", 32'(made_a), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_ctr_40", 32'(if_a.pred_ctr), 32'd1);
    check("rst_taken_40", 32'(if_a.pred_taken), 32'd0);
    check("rst_cghr", 32'(cghr_a), 32'h00);
    check("rst_made", 32'(made_a), 32'd0);
    check("rst_corr", 32'(corr_a), 32'd0);
    check("rst_ghr", 32'(if_a.pred_ghr), 32'h00);
    if_a.lookup_pc = 32'h3FC;
    #1;
    check("rst_idx_3fc", 32'(if_a.pred_index), 32'hFF);
    check("rst_ctr_3fc", 32'(if_a.pred_ctr), 32'd1);
    check("rst_taken_3fc", 32'(if_a.pred_taken), 32'd0);
    #1;
    rst = 1'b0;

    // Saturation at index 5.
    if_a.lookup_pc = 32'h14;
    if_a.resolve_valid = 1'b1; if_a.resolve_index = 8'h05; if_a.resolve_ghr = '0;
    if_a.resolve_pred_taken = 1'b1; if_a.resolve_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sat_up_%0d", i), 32'(if_a.pred_ctr), 32'(up_a[i]));
    end
    check("sat_up_taken", 32'(if_a.pred_taken), 32'd1);
    if_a.resolve_pred_taken = 1'b0; if_a.resolve_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_dn_%0d", i), 32'(if_a.pred_ctr), 32'(dn_a[i]));
    end
    if_a.resolve_valid = 1'b0;
    #1;
    check("sat_cghr", 32'(cghr_a), 32'hE0);
    check("sat_made", 32'(made_a), 32'd9);
    check("sat_corr", 32'(corr_a), 32'd9);
    check("sat_spec_ghr", 32'(if_a.pred_ghr), 32'h00);

    // Prime 0x20, 0x21, 0x23 to weakly taken, then shift speculative history.
    if_a.resolve_valid = 1'b1; if_a.resolve_pred_taken = 1'b1; if_a.resolve_taken = 1'b1;
    if_a.resolve_index = 8'h20; tick();
    if_a.resolve_index = 8'h21; tick();
    if_a.resolve_index = 8'h23; tick();
    if_a.resolve_valid = 1'b0;
    if_a.lookup_pc = 32'h80;
    #1;
    check("spec_idx0", 32'(if_a.pred_index), 32'h20);
    check("spec_taken0", 32'(if_a.pred_taken), 32'd1);
    if_a.lookup_spec = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("spec_ghr_%0d", i), 32'(if_a.pred_ghr), 32'(ghr_a[i]));
    end
    if_a.resolve_valid = 1'b1; if_a.resolve_index = 8'h55; if_a.resolve_ghr = 8'h01;
    if_a.resolve_pred_taken = 1'b1; if_a.resolve_taken = 1'b0;
    #1;
    check("mp_flag", 32'(if_a.mispredict), 32'd1);
    tick();
    check("mp_restore", 32'(if_a.pred_ghr), 32'h02);

    // Load spec_ghr = 0x0F via a mispredict, then hash and read-before-write.
    if_a.lookup_spec = 1'b0;
    if_a.resolve_index = 8'h30; if_a.resolve_ghr = 8'h07;
    if_a.resolve_pred_taken = 1'b0; if_a.resolve_taken = 1'b1;
    tick();
    if_a.resolve_valid = 1'b0;
    if_a.lookup_pc = 32'h0000_0410;
    #1;
    check("hash_ghr", 32'(if_a.pred_ghr), 32'h0F);
    check("hash_idx", 32'(if_a.pred_index), 32'h0B);
    check("hash_ctr", 32'(if_a.pred_ctr), 32'd1);
    if_a.resolve_valid = 1'b1; if_a.resolve_index = 8'h0B; if_a.resolve_ghr = 8'h0F;
    if_a.resolve_pred_taken = 1'b1; if_a.resolve_taken = 1'b1;
    #1;
    check("rbw_old", 32'(if_a.pred_ctr), 32'd1);
    check("rbw_no_mp", 32'(if_a.mispredict), 32'd0);
    tick();
    if_a.resolve_valid = 1'b0;
    #1;
    check("rbw_new", 32'(if_a.pred_ctr), 32'd2);
    check("rbw_taken", 32'(if_a.pred_taken), 32'd1);
    check("rbw_idx", 32'(if_a.pred_index), 32'h0B);

    // Bimodal: index ignores history, 3-bit counters.
    if_b.resolve_valid = 1'b1; if_b.resolve_index = 4'h2; if_b.resolve_ghr = 4'h3;
    if_b.resolve_pred_taken = 1'b0; if_b.resolve_taken = 1'b1;
    tick();
    if_b.resolve_valid = 1'b0;
    if_b.lookup_pc = 32'h24;
    #1;
    check("bim_ghr", 32'(if_b.pred_ghr), 32'h7);
    check("bim_idx", 32'(if_b.pred_index), 32'h9);
    check("bim_ctr_init", 32'(if_b.pred_ctr), 32'd3);
    check("bim_taken_init", 32'(if_b.pred_taken), 32'd0);
    if_b.resolve_valid = 1'b1; if_b.resolve_index = 4'h9; if_b.resolve_ghr = 4'h7;
    if_b.resolve_pred_taken = 1'b1; if_b.resolve_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bim_ctr_%0d", i), 32'(if_b.pred_ctr), 32'(up_b[i]));
    end
    check("bim_taken", 32'(if_b.pred_taken), 32'd1);
    if_b.resolve_valid = 1'b0;
    if_b.lookup_spec = 1'b1;
    tick();
    if_b.lookup_spec = 1'b0;
    #1;
    check("bim_ghr_shift", 32'(if_b.pred_ghr), 32'hF);
    check("bim_idx_hold", 32'(if_b.pred_index), 32'h9);

    // Statistics saturation and clear at STAT_BITS = 3.
    if_c.resolve_valid = 1'b1; if_c.resolve_index = 8'h00;
    if_c.resolve_pred_taken = 1'b1; if_c.resolve_taken = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("stat_made_%0d", i), 32'(made_c), 32'(stat_c[i]));
      check($sformatf("stat_corr_%0d", i), 32'(corr_c), 32'(stat_c[i]));
    end
    if_c.resolve_taken = 1'b0;
    tick();
    check("stat_made_hold", 32'(made_c), 32'd7);
    check("stat_corr_hold", 32'(corr_c), 32'd7);
    if_c.resolve_taken = 1'b1;
    clear_c = 1'b1;
    tick();
    clear_c = 1'b0;
    if_c.resolve_valid = 1'b0;
    #1;
    check("clr_made", 32'(made_c), 32'd0);
    check("clr_corr", 32'(corr_c), 32'd0);
    if_c.resolve_valid = 1'b1; if_c.resolve_taken = 1'b0;
    tick();
    if_c.resolve_valid = 1'b0;
    #1;
    check("post_clr_made", 32'(made_c), 32'd1);
    check("post_clr_corr", 32'(corr_c), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised direction predictor for the fetch stage: pattern history table (PHT) of saturating counters, indexed by PC hashed with global history.
- Keeps a speculative global history register (GHR), updated at fetch, and a committed GHR, updated at resolve. A mispredict restores the speculative GHR from the resolved branch's snapshot.
- Lookup at IF; resolve from EX.
- Adds configurable geometry, a bimodal mode, and saturating statistics counters.

Parameters:
- PC_BITS, 32, fetch PC width.
- INDEX_BITS, 8, log2 of PHT entry count. Legal range 4..12.
- GHR_BITS, 8, global history length. Legal range 1..INDEX_BITS.
- CTR_BITS, 2, counter width. Legal range 1..4.
- CTR_INIT, 1, reset value of every PHT counter. Must be less than 2^CTR_BITS.
- HASH_MODE, 0, index hash. 0 = gshare (PC xor GHR), 1 = bimodal (PC only).
- STAT_BITS, 13, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- lookup_pc  in  PC_BITS  fetch PC
- lookup_spec  in  1  fetch-side branch detected (BTB hit on a branch); shift prediction into speculative GHR
- pred_taken  out  1  predicted direction (counter MSB)
- pred_ctr  out  CTR_BITS  counter value read
- pred_index  out  INDEX_BITS  PHT index used; carried down the pipe
- pred_ghr  out  GHR_BITS  speculative GHR used for this lookup; carried down the pipe
- resolve_valid  in  1  conditional branch resolved in EX
- resolve_index  in  INDEX_BITS  index captured at lookup
- resolve_ghr  in  GHR_BITS  GHR snapshot captured at lookup
- resolve_pred_taken  in  1  direction predicted at lookup
- resolve_taken  in  1  actual direction
- mispredict  out  1  combinational: resolve_valid && (resolve_taken != resolve_pred_taken)
- clear_stats  in  1  synchronous clear of the statistics counters
- predictions_made  out  STAT_BITS  resolved branch count
- correct_predictions  out  STAT_BITS  correct prediction count
- committed_ghr  out  GHR_BITS  architectural history

Behaviour:
- Index calculation:
  - pc_idx = lookup_pc[INDEX_BITS+1:2].
  - HASH_MODE 0: index = pc_idx xor zero-extended spec_ghr.
  - HASH_MODE 1: index = pc_idx; GHRs are still maintained.
- Lookup timing: combinational, zero latency. pred_* are valid in the same cycle as lookup_pc; the PHT read is asynchronous from flops.
- Speculative GHR, at each clock edge, in priority order:
  - If mispredict: spec_ghr <= {resolve_ghr[GHR_BITS-2:0], resolve_taken}. This overrides any same-cycle lookup_spec. For GHR_BITS = 1, spec_ghr <= resolve_taken.
  - Else if lookup_spec: spec_ghr <= {spec_ghr[GHR_BITS-2:0], pred_taken}.
  - Else: hold.
- Committed GHR: on resolve_valid, committed_ghr <= {committed_ghr[GHR_BITS-2:0], resolve_taken}.
- PHT update on resolve_valid, always a saturating update regardless of prediction correctness:
  - Taken: increment, clamped at 2^CTR_BITS-1.
  - Not taken: decrement, clamped at 0.
- Read/write collision: if lookup and update hit the same index in the same cycle, the lookup returns the pre-update value. There is no bypass.
- Statistics, on resolve_valid:
  - predictions_made += 1.
  - correct_predictions += 1 when resolve_taken == resolve_pred_taken.
  - Both saturate at all-ones; they never wrap.
  - clear_stats zeroes both. If resolve_valid is asserted in the same cycle, clear_stats wins and that event is not counted.
- Reset (asynchronous, any time, including mid-resolve):
  - All PHT counters = CTR_INIT.
  - spec_ghr = 0, committed_ghr = 0.
  - Statistics = 0.
  - pred_* reflect the reset state immediately.
  - On deassertion, the first edge operates normally.
- Unknown or illegal inputs: none. Each resolve is handled independently in one cycle, with no internal queueing. The block keeps no pending state between resolves.

Decomposition:
- Shared package bp_pkg:
  - HASH_GSHARE / HASH_BIMODAL constants.
  - Function sat_update(ctr, taken, width).
  - Function gshare_hash(pc_idx, ghr).
- One sub-module bp_counter_table:
  - 2^INDEX_BITS x CTR_BITS flop array.
  - One asynchronous read port, one synchronous write port, asynchronous reset to CTR_INIT.
- GHR logic and statistics stay in gshare_predictor.

Test Plan:
- Reset behaviour: assert rst asynchronously mid-cycle, with defaults -> pred_ctr = 1, pred_taken = 0 for PC 0x40 and 0x3FC; committed_ghr = 0; stats = 0.
- Counter saturation: resolve index 5 as taken four times -> pred_ctr at that index goes 1 → 2 → 3 → 3 and pred_taken = 1; then five not-taken resolves -> counter reaches 0 and holds.
- Speculative shift with mispredict priority: lookup_spec with pred_taken = 1 for three cycles -> spec_ghr = 0x07. Then, with resolve_ghr = 0x01, resolve_pred_taken = 1, resolve_taken = 0 and lookup_spec high in the same cycle -> spec_ghr = 0x02, mispredict = 1.
- gshare hash and read-before-write: PC 0x0000_0410, spec_ghr 0x0F -> pred_index = 0x04 xor 0x0F = 0x0B. A same-cycle update to index 0x0B returns the old counter; the next cycle returns the updated one.
- Bimodal mode (HASH_MODE = 1, INDEX_BITS = 4, CTR_BITS = 3, CTR_INIT = 3) -> index ignores GHR, taken threshold is ctr >= 4, saturation at 7.
- Statistics saturation and clear (STAT_BITS = 3):
  - Nine resolves, all correct -> both counters hold at 7.
  - clear_stats together with resolve_valid -> both counters read 0 on the next cycle.
